// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// pipe_stall_ctrl_pkg : stall encodings, FSM states, defaults   | Rev 1.0
// ==========================================================================
package pipe_stall_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam int STALL_W   = STALL_WB + 1;

  typedef logic [STALL_W-1:0] stall_t;

  localparam stall_t STALL_NONE    = 6'b000000;
  localparam stall_t STALL_LOADUSE = stall_t'((1 << STALL_PC) | (1 << STALL_IF) | (1 << STALL_ID));
  localparam stall_t STALL_EXHOLD  = STALL_LOADUSE | stall_t'(1 << STALL_EX);

  localparam int CNT_W_DEF   = 6;
  localparam int MAX_LEN_DEF = 33;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_mc_sequencer.sv
`default_nettype none
// ==========================================================================
// mc_sequencer : multi-cycle EX countdown, length clamp, last-cycle flag | Rev 1.0
// ==========================================================================
module mc_sequencer
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             busy_i,
  input  logic             abort_i,
  output logic             launch_o,
  output logic             hold_o,
  output logic             last_o,
  output logic             done_o
);

  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign len_eff  = CNT_W'(clamp_len(32'(len_i), 32'(MAX_LEN)));
  assign launch_o = start_i & (len_eff >= CNT_W'(2));
  assign done_o   = busy_i & (cnt_q == '0);
  assign hold_o   = launch_o | (busy_i & (cnt_q != '0));
  // Degenerate lengths (0/1) complete in the start cycle without holding EX.
  assign last_o   = ~abort_i & ((start_i & ~launch_o) | done_o);

  always_comb begin
    cnt_d = cnt_q;
    if (abort_i) begin
      cnt_d = '0;
    end else if (launch_o) begin
      cnt_d = len_eff - CNT_W'(2);
    end else if (busy_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ==========================================================================
// pipe_stall_ctrl : stall vector, load-use detect, flush/redirect owner | Rev 1.0
// ==========================================================================
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_is_load_i,
  input  logic [4:0]        ex_wd_i,
  input  logic              id_reg1_read_i,
  input  logic [4:0]        id_reg1_addr_i,
  input  logic              id_reg2_read_i,
  input  logic [4:0]        id_reg2_addr_i,
  input  logic              mc_start_i,
  input  logic [CNT_W-1:0]  mc_len_i,
  input  logic              flush_req_i,
  input  logic [31:0]       flush_pc_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              mc_busy_o,
  output logic              mc_last_o,
  output logic [PERF_W-1:0] stall_cycles_o
);

  state_e              state_q;
  logic                flush_q;
  logic                ld_stalled_q;
  logic [31:0]         new_pc_q;
  logic [PERF_W-1:0]   perf_q;
  logic [PERF_W-1:0]   perf_d;
  stall_t              stall_d;

  logic in_idle, in_busy, hazard, loaduse_stall, mc_start_ok;
  logic mc_launch, mc_hold, mc_last, mc_done;

  assign in_idle = (state_q == ST_IDLE);
  assign in_busy = (state_q == ST_MC_BUSY);

  assign hazard = ex_is_load_i & (ex_wd_i != 5'd0) &
                  ((id_reg1_read_i & (id_reg1_addr_i == ex_wd_i)) |
                   (id_reg2_read_i & (id_reg2_addr_i == ex_wd_i)));

  assign mc_start_ok = in_idle & mc_start_i & ~flush_req_i;

  mc_sequencer #(
    .CNT_W   (CNT_W),
    .MAX_LEN (MAX_LEN)
  ) u_mc_sequencer (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mc_start_ok),
    .len_i    (mc_len_i),
    .busy_i   (in_busy),
    .abort_i  (flush_req_i),
    .launch_o (mc_launch),
    .hold_o   (mc_hold),
    .last_o   (mc_last),
    .done_o   (mc_done)
  );

  // A load-use bubble is inserted once; the load has left EX by the next cycle.
  assign loaduse_stall = in_idle & hazard & ~ld_stalled_q & ~flush_req_i & ~mc_launch;

  always_comb begin
    stall_d = STALL_NONE;
    if (rst || flush_req_i) begin
      stall_d = STALL_NONE;
    end else if (mc_hold) begin
      stall_d = STALL_EXHOLD;
    end else if (loaduse_stall) begin
      stall_d = STALL_LOADUSE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      flush_q      <= 1'b0;
      new_pc_q     <= 32'd0;
      ld_stalled_q <= 1'b0;
    end else if (flush_req_i) begin
      state_q      <= ST_FLUSH;
      flush_q      <= 1'b1;
      new_pc_q     <= flush_pc_i;
      ld_stalled_q <= 1'b0;
    end else begin
      flush_q      <= 1'b0;
      ld_stalled_q <= loaduse_stall;
      case (state_q)
        ST_IDLE:    if (mc_launch) state_q <= ST_MC_BUSY;
        ST_MC_BUSY: if (mc_done)   state_q <= ST_IDLE;
        default:                   state_q <= ST_IDLE;
      endcase
    end
  end

  assign perf_d = ((stall_d != STALL_NONE) && (perf_q != '1)) ? perf_q + PERF_W'(1) : perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign stall_o        = stall_d;
  assign flush_o        = flush_q & ~rst;
  assign new_pc_o       = rst ? 32'd0 : new_pc_q;
  assign mc_busy_o      = in_busy & ~rst;
  assign mc_last_o      = mc_last & ~rst;
  assign stall_cycles_o = rst ? '0 : perf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// tb_pipe_stall_ctrl : directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the stall/flush rules.
module tb_pipe_stall_ctrl;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LU   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_is_load, id_reg1_read, id_reg2_read, mc_start, flush_req;
  logic [4:0]  ex_wd, id_reg1_addr, id_reg2_addr;
  logic [5:0]  mc_len;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush, mc_busy, mc_last;
  logic [31:0] new_pc;
  logic [15:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  pipe_stall_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_is_load_i   (ex_is_load),
    .ex_wd_i        (ex_wd),
    .id_reg1_read_i (id_reg1_read),
    .id_reg1_addr_i (id_reg1_addr),
    .id_reg2_read_i (id_reg2_read),
    .id_reg2_addr_i (id_reg2_addr),
    .mc_start_i     (mc_start),
    .mc_len_i       (mc_len),
    .flush_req_i    (flush_req),
    .flush_pc_i     (flush_pc),
    .stall_o        (stall),
    .flush_o        (flush),
    .new_pc_o       (new_pc),
    .mc_busy_o      (mc_busy),
    .mc_last_o      (mc_last),
    .stall_cycles_o (stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 normal, 1 multi-cycle in EX, 2 redirect cycle.
  // m_left = EX cycles the multi-cycle op still occupies after the start cycle.
  int          m_mode    = 0;
  int          m_left    = 0;
  bit          m_ld_prev = 1'b0;
  logic [31:0] m_pc      = 32'd0;
  int          m_perf    = 0;
  int          m_len;
  logic        m_haz;

  logic [5:0]  e_stall;
  logic        e_flush, e_busy, e_last;
  logic [15:0] e_perf;

  assign m_len = (int'(mc_len) > 33) ? 33 : int'(mc_len);
  assign m_haz = ex_is_load && (ex_wd != 5'd0) &&
                 ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                  (id_reg2_read && (id_reg2_addr == ex_wd)));

  always_comb begin
    e_stall = S_NONE;
    e_flush = 1'b0;
    e_busy  = 1'b0;
    e_last  = 1'b0;
    e_perf  = rst ? 16'd0 : 16'(m_perf);
    if (!rst) begin
      e_flush = (m_mode == 2);
      e_busy  = (m_mode == 1);
      if (!flush_req) begin
        if (m_mode == 0) begin
          if (mc_start && m_len >= 2) begin
            e_stall = S_EX;
          end else begin
            if (mc_start) e_last = 1'b1;
            if (m_haz && !m_ld_prev) e_stall = S_LU;
          end
        end else if (m_mode == 1) begin
          if (m_left > 1) e_stall = S_EX;
          else            e_last  = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_left <= 0; m_ld_prev <= 1'b0; m_pc <= 32'd0; m_perf <= 0;
    end else begin
      if (e_stall != S_NONE && m_perf < 65535) m_perf <= m_perf + 1;
      m_ld_prev <= (e_stall == S_LU);
      if (flush_req) begin
        m_mode <= 2; m_pc <= flush_pc; m_left <= 0;
      end else if (m_mode == 0) begin
        if (mc_start && m_len >= 2) begin m_mode <= 1; m_left <= m_len - 1; end
      end else if (m_mode == 1) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_mode <= 0;
      end else begin
        m_mode <= 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_is_load = 0; ex_wd = 0; id_reg1_read = 0; id_reg1_addr = 0;
    id_reg2_read = 0; id_reg2_addr = 0; mc_start = 0; mc_len = 0;
    flush_req = 0; flush_pc = 0;
  endtask

  task automatic do_reset;
    rst = 1; idle_inputs(); tick(); rst = 0;
  endtask

  task automatic set_hazard(input logic [4:0] wd);
    ex_is_load = 1; ex_wd = wd; id_reg1_read = 1; id_reg1_addr = wd;
  endtask

  task automatic test_reset;
    rst = 1; set_hazard(5'd5); mc_start = 1; mc_len = 6'd4; flush_req = 0; flush_pc = 32'h1234;
    @(negedge clk);
    n_vec++; if (stall !== S_NONE) begin n_err++; $display("FAIL reset_stall: got %b want %b", stall, S_NONE); end
    n_vec++; if (mc_last !== 1'b0) begin n_err++; $display("FAIL reset_mc_last: got %b want 0", mc_last); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_vec++; if (mc_busy !== 1'b0) begin n_err++; $display("FAIL reset_mc_busy: got %b want 0", mc_busy); end
    tick(); rst = 0; idle_inputs();
    @(negedge clk);
    n_vec++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_perf: got %0d want 0", stall_cycles); end
    n_vec++; if (new_pc !== 32'd0) begin n_err++; $display("FAIL reset_new_pc: got %h want 0", new_pc); end
    n_vec++; if (mc_busy !== 1'b0 || flush !== 1'b0) begin n_err++; $display("FAIL reset_after: got busy=%b flush=%b want 0/0", mc_busy, flush); end
    tick();
  endtask

  task automatic test_loaduse;
    do_reset(); set_hazard(5'd5);
    @(negedge clk);
    n_vec++; if (stall !== S_LU) begin n_err++; $display("FAIL lu_first: got %b want %b", stall, S_LU); end
    tick();
    @(negedge clk);
    n_vec++; if (stall !== S_NONE) begin n_err++; $display("FAIL lu_second: got %b want %b", stall, S_NONE); end
    tick(); idle_inputs();
    @(negedge clk);
    n_vec++; if (stall_cycles !== 16'd1) begin n_err++; $display("FAIL lu_perf: got %0d want 1", stall_cycles); end
    tick();
    ex_is_load = 1; ex_wd = 5'd7; id_reg2_read = 1; id_reg2_addr = 5'd7;
    @(negedge clk);
    n_vec++; if (stall !== S_LU) begin n_err++; $display("FAIL lu_port2: got %b want %b", stall, S_LU); end
    tick(); idle_inputs();
  endtask

  task automatic test_reg_zero;
    do_reset(); set_hazard(5'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++; if (stall !== S_NONE) begin n_err++; $display("FAIL r0_stall c%0d: got %b want %b", c, stall, S_NONE); end
      tick();
    end
    ex_is_load = 1; ex_wd = 5'd9; id_reg1_read = 0; id_reg1_addr = 5'd9; id_reg2_read = 1; id_reg2_addr = 5'd8;
    @(negedge clk);
    n_vec++; if (stall !== S_NONE) begin n_err++; $display("FAIL nohaz_unread: got %b want %b", stall, S_NONE); end
    tick(); idle_inputs();
    @(negedge clk);
    n_vec++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL r0_perf: got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_multicycle;
    logic [5:0] xs;
    do_reset(); mc_start = 1; mc_len = 6'd4;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      xs = (c < 3) ? S_EX : S_NONE;
      n_vec++; if (stall !== xs) begin n_err++; $display("FAIL mc4_stall c%0d: got %b want %b", c, stall, xs); end
      n_vec++; if (mc_last !== (c == 3)) begin n_err++; $display("FAIL mc4_last c%0d: got %b want %b", c, mc_last, (c == 3)); end
      n_vec++; if (mc_busy !== (c >= 1 && c <= 3)) begin n_err++; $display("FAIL mc4_busy c%0d: got %b want %b", c, mc_busy, (c >= 1 && c <= 3)); end
      tick(); mc_start = 0;
      if (c == 2) set_hazard(5'd3);
      if (c == 3) idle_inputs();
    end
    n_vec++; if (stall_cycles !== 16'd3) begin n_err++; $display("FAIL mc4_perf: got %0d want 3", stall_cycles); end
  endtask

  task automatic test_clamp;
    int n_st;
    bit seen;
    do_reset(); mc_start = 1; mc_len = 6'd63;
    n_st = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (stall === S_EX) n_st++;
      if (mc_last === 1'b1) seen = 1;
      tick(); mc_start = 0;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL clamp_last: got no mc_last within 40 cycles want mc_last"); end
    n_vec++; if (n_st != 32) begin n_err++; $display("FAIL clamp_stalls: got %0d want 32", n_st); end
    for (int k = 0; k < 2; k++) begin
      mc_start = 1; mc_len = 6'(1 - k);
      @(negedge clk);
      n_vec++; if (stall !== S_NONE || mc_last !== 1'b1) begin n_err++; $display("FAIL len%0d_start: got stall=%b last=%b want 000000/1", 1 - k, stall, mc_last); end
      tick(); mc_start = 0;
      @(negedge clk);
      n_vec++; if (mc_busy !== 1'b0 || mc_last !== 1'b0) begin n_err++; $display("FAIL len%0d_after: got busy=%b last=%b want 0/0", 1 - k, mc_busy, mc_last); end
      tick();
    end
  endtask

  task automatic test_flush_midop;
    bit any_last;
    do_reset(); mc_start = 1; mc_len = 6'd10;
    tick(); mc_start = 0;
    tick(); tick();
    flush_req = 1; flush_pc = 32'h0000_0180;
    @(negedge clk);
    n_vec++; if (stall !== S_NONE || mc_last !== 1'b0) begin n_err++; $display("FAIL fl_req_cycle: got stall=%b last=%b want 000000/0", stall, mc_last); end
    tick(); flush_pc = 32'h0000_0200;
    @(negedge clk);
    n_vec++; if (flush !== 1'b1 || new_pc !== 32'h180) begin n_err++; $display("FAIL fl_redirect: got flush=%b pc=%h want 1/180", flush, new_pc); end
    n_vec++; if (stall !== S_NONE || mc_busy !== 1'b0) begin n_err++; $display("FAIL fl_quiet: got stall=%b busy=%b want 000000/0", stall, mc_busy); end
    tick(); flush_req = 0;
    @(negedge clk);
    n_vec++; if (flush !== 1'b1 || new_pc !== 32'h200) begin n_err++; $display("FAIL fl_reenter: got flush=%b pc=%h want 1/200", flush, new_pc); end
    tick();
    any_last = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mc_last === 1'b1 || mc_busy === 1'b1 || flush === 1'b1) any_last = 1;
      tick();
    end
    n_vec++; if (any_last) begin n_err++; $display("FAIL fl_idle_after: got activity after abort want idle"); end
  endtask

  task automatic test_reset_midop;
    do_reset(); mc_start = 1; mc_len = 6'd10;
    tick(); mc_start = 0; tick();
    rst = 1;
    @(negedge clk);
    n_vec++; if (stall !== S_NONE || mc_busy !== 1'b0 || mc_last !== 1'b0) begin n_err++; $display("FAIL rm_during: got stall=%b busy=%b last=%b want 0s", stall, mc_busy, mc_last); end
    tick(); rst = 0;
    @(negedge clk);
    n_vec++; if (stall !== S_NONE || mc_busy !== 1'b0 || stall_cycles !== 16'd0) begin n_err++; $display("FAIL rm_after: got stall=%b busy=%b perf=%0d want 0s", stall, mc_busy, stall_cycles); end
    tick(); mc_start = 1; mc_len = 6'd2;
    @(negedge clk);
    n_vec++; if (stall !== S_EX) begin n_err++; $display("FAIL rm_len2_start: got %b want %b", stall, S_EX); end
    tick(); mc_start = 0;
    @(negedge clk);
    n_vec++; if (stall !== S_NONE || mc_last !== 1'b1) begin n_err++; $display("FAIL rm_len2_last: got stall=%b last=%b want 000000/1", stall, mc_last); end
    tick();
    @(negedge clk);
    n_vec++; if (stall_cycles !== 16'd1) begin n_err++; $display("FAIL rm_perf: got %0d want 1", stall_cycles); end
    tick();
  endtask

  task automatic test_random;
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      flush_req    = ($urandom_range(0, 15) == 0);
      flush_pc     = $urandom;
      mc_start     = ($urandom_range(0, 7) == 0);
      mc_len       = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(0, 63));
      ex_is_load   = 1'($urandom_range(0, 1));
      ex_wd        = 5'($urandom_range(0, 3));
      id_reg1_read = 1'($urandom_range(0, 1));
      id_reg1_addr = 5'($urandom_range(0, 3));
      id_reg2_read = 1'($urandom_range(0, 1));
      id_reg2_addr = 5'($urandom_range(0, 3));
      @(negedge clk);
      n_vec++; if (stall !== e_stall) begin n_err++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, e_stall); end
      n_vec++; if (flush !== e_flush) begin n_err++; $display("FAIL rnd_flush c%0d: got %b want %b", c, flush, e_flush); end
      n_vec++; if (mc_busy !== e_busy) begin n_err++; $display("FAIL rnd_busy c%0d: got %b want %b", c, mc_busy, e_busy); end
      n_vec++; if (mc_last !== e_last) begin n_err++; $display("FAIL rnd_last c%0d: got %b want %b", c, mc_last, e_last); end
      n_vec++; if (stall_cycles !== e_perf) begin n_err++; $display("FAIL rnd_perf c%0d: got %0d want %0d", c, stall_cycles, e_perf); end
      if (e_flush) begin
        n_vec++; if (new_pc !== m_pc) begin n_err++; $display("FAIL rnd_new_pc c%0d: got %h want %h", c, new_pc, m_pc); end
      end
      tick();
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_loaduse();
    test_reg_zero();
    test_multicycle();
    test_clamp();
    test_flush_midop();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion within time limit want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
